// File: rtl/segment_stream_engine.sv
// Streams a programmable address window out of a DIM-lane image buffer as gapped bursts over valid/ready.
// Optional feature macro: SEGSTREAM_LOOP_EN adds the loop_i port, which re-arms the pass at its final beat.
`timescale 1ns/1ps
module segment_stream_engine #(
  parameter int DIM     = 8,
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8192,
  parameter int ADDR    = $clog2(DEPTH),
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic [ADDR-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0]   din_i [DIM],
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [ADDR-1:0]    base_addr_i,
  input  logic [ADDR:0]      num_words_i,
  input  logic [BURST_W-1:0] burst_len_i,
  input  logic [BURST_W-1:0] gap_len_i,
`ifdef SEGSTREAM_LOOP_EN
  input  logic               loop_i,
`endif
  input  logic               out_ready_i,
  output logic               out_valid_o,
  output logic [WIDTH-1:0]   data_out_o [DIM],
  output logic               burst_last_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2,
    FLUSH = 2'd3
  } state_e;

  localparam logic [ADDR-1:0]    ADDR_LAST = ADDR'(DEPTH - 1);
  localparam logic [ADDR-1:0]    ADDR_ONE  = {{(ADDR-1){1'b0}}, 1'b1};
  localparam logic [ADDR:0]      REM_ONE   = {{ADDR{1'b0}}, 1'b1};
  localparam logic [ADDR:0]      REM_ZERO  = {(ADDR+1){1'b0}};
  localparam logic [BURST_W-1:0] CNT_ONE   = {{(BURST_W-1){1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] CNT_ZERO  = {BURST_W{1'b0}};

  logic [DIM*WIDTH-1:0] mem [DEPTH];
  logic [DIM*WIDTH-1:0] din_packed_s;

  state_e               state_q, state_d;
  logic [ADDR-1:0]      addr_q, addr_d;
  logic [ADDR:0]        remain_q, remain_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [BURST_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [BURST_W-1:0]   burst_len_q, burst_len_d;
  logic [BURST_W-1:0]   gap_len_q, gap_len_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [DIM*WIDTH-1:0] data_q;
  logic                 issue_s;
  logic                 eop_s;
  logic                 eob_s;
  logic                 hs_s;
  logic [ADDR-1:0]      addr_nxt_s;
  logic [BURST_W-1:0]   burst_nxt_s;
`ifdef SEGSTREAM_LOOP_EN
  logic                 loop_q, loop_d;
  logic [ADDR-1:0]      base_q, base_d;
  logic [ADDR:0]        num_q, num_d;
  logic                 pass_end_q, pass_end_d;
`endif

  // Flatten the write lanes into one memory word
  always_comb begin
    din_packed_s = {(DIM*WIDTH){1'b0}};
    for (int k = 0; k < DIM; k++) begin
      din_packed_s[k*WIDTH +: WIDTH] = din_i[k];
    end
  end

  // Expose the output data register lane by lane
  always_comb begin
    for (int k = 0; k < DIM; k++) begin
      data_out_o[k] = data_q[k*WIDTH +: WIDTH];
    end
  end

  // Write port; memory contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[wr_addr_i] <= din_packed_s;
    end
  end

  // Synchronous read into the output register; a same-cycle write returns the old word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= {(DIM*WIDTH){1'b0}};
    end else if (issue_s) begin
      data_q <= mem[addr_q];
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    burst_cnt_d = burst_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    burst_len_d = burst_len_q;
    gap_len_d   = gap_len_q;
    valid_d     = valid_q;
    last_d      = last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    issue_s     = 1'b0;
`ifdef SEGSTREAM_LOOP_EN
    loop_d      = loop_q;
    base_d      = base_q;
    num_d       = num_q;
    pass_end_d  = pass_end_q;
`endif
    hs_s        = valid_q && out_ready_i;
    eop_s       = (remain_q == REM_ONE);
    burst_nxt_s = burst_cnt_q + CNT_ONE;
    eob_s       = (burst_len_q != CNT_ZERO) && (burst_nxt_s == burst_len_q);
    addr_nxt_s  = (addr_q == ADDR_LAST) ? {ADDR{1'b0}} : (addr_q + ADDR_ONE);

    if (hs_s) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
`ifdef SEGSTREAM_LOOP_EN
      pass_end_d = 1'b0;
      done_d     = pass_end_q;
`endif
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d      = base_addr_i;
          remain_d    = num_words_i;
          burst_len_d = burst_len_i;
          gap_len_d   = gap_len_i;
          burst_cnt_d = CNT_ZERO;
          busy_d      = 1'b1;
`ifdef SEGSTREAM_LOOP_EN
          loop_d = loop_i;
          base_d = base_addr_i;
          num_d  = num_words_i;
`endif
          state_d = (num_words_i != REM_ZERO) ? BURST : FLUSH;
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        if (!valid_q || out_ready_i) begin
          issue_s  = 1'b1;
          valid_d  = 1'b1;
          last_d   = eop_s || eob_s;
          addr_d   = addr_nxt_s;
          remain_d = remain_q - REM_ONE;
`ifdef SEGSTREAM_LOOP_EN
          pass_end_d = eop_s;
`endif
          if (eop_s) begin
`ifdef SEGSTREAM_LOOP_EN
            if (loop_q) begin
              addr_d      = base_q;
              remain_d    = num_q;
              burst_cnt_d = CNT_ZERO;
            end else begin
              state_d = FLUSH;
            end
`else
            state_d = FLUSH;
`endif
          end else if (eob_s) begin
            burst_cnt_d = CNT_ZERO;
            gap_cnt_d   = gap_len_q;
            state_d     = (gap_len_q != CNT_ZERO) ? GAP : BURST;
          end else begin
            burst_cnt_d = burst_nxt_s;
          end
        end else begin
          state_d = BURST;
        end
      end
      GAP: begin
        // The gap runs on cycles, not handshakes, so a stalled sink does not stretch it
        if (gap_cnt_q <= CNT_ONE) begin
          state_d = BURST;
        end else begin
          gap_cnt_d = gap_cnt_q - CNT_ONE;
        end
      end
      FLUSH: begin
        if (!valid_q || out_ready_i) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = FLUSH;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (abort_i) begin
      state_d = IDLE;
      issue_s = 1'b0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
`ifdef SEGSTREAM_LOOP_EN
      pass_end_d = 1'b0;
`endif
    end else begin
      busy_d = busy_d;
    end
  end

  // Control and output state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= {ADDR{1'b0}};
      remain_q    <= REM_ZERO;
      burst_cnt_q <= CNT_ZERO;
      gap_cnt_q   <= CNT_ZERO;
      burst_len_q <= CNT_ZERO;
      gap_len_q   <= CNT_ZERO;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SEGSTREAM_LOOP_EN
      loop_q      <= 1'b0;
      base_q      <= {ADDR{1'b0}};
      num_q       <= REM_ZERO;
      pass_end_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      burst_cnt_q <= burst_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      burst_len_q <= burst_len_d;
      gap_len_q   <= gap_len_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SEGSTREAM_LOOP_EN
      loop_q      <= loop_d;
      base_q      <= base_d;
      num_q       <= num_d;
      pass_end_q  <= pass_end_d;
`endif
    end
  end

  assign out_valid_o  = valid_q;
  assign burst_last_o = last_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_segment_stream_engine.sv
// Directed bench for segment_stream_engine: a scoreboard of expected beats checked at every handshake.
`timescale 1ns/1ps
module tb_segment_stream_engine;
  localparam int DIM   = 8;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8192;
  localparam int ADDR  = 13;
  localparam int BW    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             we;
  logic [ADDR-1:0]  wr_addr;
  logic [WIDTH-1:0] din [DIM];
  logic             start;
  logic             abort;
  logic [ADDR-1:0]  base_addr;
  logic [ADDR:0]    num_words;
  logic [BW-1:0]    burst_len;
  logic [BW-1:0]    gap_len;
`ifdef SEGSTREAM_LOOP_EN
  logic             loop_en;
`endif
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] dout [DIM];
  logic             burst_last;
  logic             busy;
  logic             done;

  logic [DIM*WIDTH-1:0] dout_packed;
  logic [DIM*WIDTH:0]   sb [$];
  logic [DIM*WIDTH:0]   hold_val;
  logic [DIM*WIDTH:0]   exp_beat;
  bit                   hold_pending = 1'b0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int first_valid_cyc = -1;
  int valid_cycles = 0;
  int pops = 0;
  int t_start = 0;

  segment_stream_engine dut (
    .clk          (clk),
    .rst          (rst),
    .we_i         (we),
    .wr_addr_i    (wr_addr),
    .din_i        (din),
    .start_i      (start),
    .abort_i      (abort),
    .base_addr_i  (base_addr),
    .num_words_i  (num_words),
    .burst_len_i  (burst_len),
    .gap_len_i    (gap_len),
`ifdef SEGSTREAM_LOOP_EN
    .loop_i       (loop_en),
`endif
    .out_ready_i  (out_ready),
    .out_valid_o  (out_valid),
    .data_out_o   (dout),
    .burst_last_o (burst_last),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    dout_packed = '0;
    for (int k = 0; k < DIM; k++) dout_packed[k*WIDTH +: WIDTH] = dout[k];
  end

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DIM*WIDTH-1:0] word_of(input int a);
    logic [DIM*WIDTH-1:0] w;
    logic [WIDTH-1:0] lane;
    w = '0;
    for (int k = 0; k < DIM; k++) begin
      lane = WIDTH'(a + k);
      w[k*WIDTH +: WIDTH] = lane;
    end
    return w;
  endfunction

  task automatic push_pass(input int base, input int num, input int blen);
    int a;
    logic last;
    for (int i = 0; i < num; i++) begin
      a = (base + i) % DEPTH;
      last = (i + 1 == num) || (blen != 0 && ((i + 1) % blen) == 0);
      sb.push_back({last, word_of(a)});
    end
  endtask

  task automatic write_word(input int a);
    we = 1'b1;
    wr_addr = ADDR'(a);
    for (int k = 0; k < DIM; k++) din[k] = WIDTH'(a + k);
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic start_pass(input int base, input int num, input int blen, input int gap, input bit lp);
    start = 1'b1;
    base_addr = ADDR'(base);
    num_words = (ADDR+1)'(num);
    burst_len = BW'(blen);
    gap_len = BW'(gap);
`ifdef SEGSTREAM_LOOP_EN
    loop_en = lp;
`endif
    t_start = cyc;
    first_valid_cyc = -1;
    valid_cycles = 0;
    pops = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(tag, done_cnt != d0, 1);
  endtask

  // Monitor: scoreboard pops on handshake, hold-stable check while stalled
  always @(negedge clk) begin
    if (rst) begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid) begin
        valid_cycles++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (hold_pending) chk("hold_stable", {out_valid, burst_last, dout_packed}, {1'b1, hold_val});
      hold_pending = out_valid && !out_ready;
      hold_val = {burst_last, dout_packed};
      if (out_valid && out_ready) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_beat observed=%0h expected=none", dout_packed);
        end
        if (sb.size() != 0) begin
          exp_beat = sb.pop_front();
          pops++;
          chk("beat", {burst_last, dout_packed}, exp_beat);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int d0;
    we = 1'b0; wr_addr = '0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    base_addr = '0; num_words = '0; burst_len = '0; gap_len = '0;
`ifdef SEGSTREAM_LOOP_EN
    loop_en = 1'b0;
`endif
    for (int k = 0; k < DIM; k++) din[k] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", burst_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", dout_packed, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int a = 0; a < 16; a++) write_word(a);
    write_word(DEPTH - 2);
    write_word(DEPTH - 1);

    // Continuous pass of 16 beats
    push_pass(0, 16, 0);
    start_pass(0, 16, 0, 0, 1'b0);
    wait_done("t1_done_seen", 100);
    chk("t1_first_valid", first_valid_cyc, t_start + 2);
    chk("t1_done_cycle", done_cyc, t_start + 18);
    chk("t1_valid_cycles", valid_cycles, 16);
    chk("t1_sb_empty", sb.size(), 0);
    chk("t1_busy_after", busy, 0);

    // Two bursts of 4 with a gap of 3
    push_pass(0, 8, 4);
    start_pass(0, 8, 4, 3, 1'b0);
    wait_done("t2_done_seen", 100);
    chk("t2_first_valid", first_valid_cyc, t_start + 2);
    chk("t2_done_cycle", done_cyc, t_start + 13);
    chk("t2_valid_cycles", valid_cycles, 8);
    chk("t2_sb_empty", sb.size(), 0);

    // Backpressure: ready toggles every cycle
    push_pass(0, 16, 0);
    start_pass(0, 16, 0, 0, 1'b0);
    n = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < 200) begin
      out_ready = ~out_ready;
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b1;
    chk("t3_done_seen", done_cnt != d0, 1);
    chk("t3_pops", pops, 16);
    chk("t3_sb_empty", sb.size(), 0);

    // Abort while the 3rd beat is presented
    push_pass(0, 16, 0);
    start_pass(0, 16, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_valid_at_abort", out_valid, 1);
    abort = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("t6_valid_after", out_valid, 0);
    chk("t6_busy_after", busy, 0);
    chk("t6_pops", pops, 3);
    sb.delete();
    repeat (20) @(posedge clk);
    #1;
    chk("t6_no_done", done_cnt, d0);
    chk("t6_valid_cycles", valid_cycles, 3);

    // Address wrap across the top of memory
    push_pass(DEPTH - 2, 4, 0);
    start_pass(DEPTH - 2, 4, 0, 0, 1'b0);
    wait_done("t4_done_seen", 100);
    chk("t4_done_cycle", done_cyc, t_start + 6);
    chk("t4_pops", pops, 4);
    chk("t4_sb_empty", sb.size(), 0);

    // Empty pass, then a start while busy
    start_pass(0, 0, 0, 0, 1'b0);
    wait_done("t5_done_seen", 20);
    chk("t5_done_cycle", done_cyc, t_start + 2);
    chk("t5_no_valid", valid_cycles, 0);
    push_pass(0, 8, 0);
    start_pass(0, 8, 0, 0, 1'b0);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = ADDR'(4);
    num_words = (ADDR+1)'(3);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t5b_done_seen", 100);
    chk("t5b_done_cycle", done_cyc, t_start + 10);
    d0 = done_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("t5b_single_done", done_cnt, d0);
    chk("t5b_valid_cycles", valid_cycles, 8);
    chk("t5b_sb_empty", sb.size(), 0);

`ifdef SEGSTREAM_LOOP_EN
    // Looping pass of 4 beats, stopped by abort after three wraps
    for (int p = 0; p < 4; p++) push_pass(0, 4, 0);
    d0 = done_cnt;
    start_pass(0, 4, 0, 0, 1'b1);
    n = 0;
    while (pops < 12 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("loop_reached_12", pops >= 12, 1);
    chk("loop_busy", busy, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("loop_done_count", done_cnt - d0, 3);
    chk("loop_pops", pops, 13);
    chk("loop_busy_after", busy, 0);
    chk("loop_valid_after", out_valid, 0);
    sb.delete();
`endif

    chk("final_sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
